// File: rtl/serial_chunk_adder_if.sv
// serial_chunk_adder_if
//   Handshake bundle for serial_chunk_adder: the operand side (in_valid/in_ready,
//   a, b, cin) and the result side (out_valid/out_ready, s, cout).
//   slave  : the adder itself
//   master : the producer/consumer driving the adder
//   With SERIAL_ADDER_SUB_EN defined the bundle also carries 'sub', which is
//   sampled together with a/b at acceptance.
interface serial_chunk_adder_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             out_valid;
   logic             out_ready;

`ifdef SERIAL_ADDER_SUB_EN
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, s, cout, out_valid
   );
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, s, cout, out_valid
   );
`else
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, s, cout, out_valid
   );
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, s, cout, out_valid
   );
`endif
endinterface

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Multi-cycle WIDTH-bit adder that adds CHUNK bits per clock through a single
//   CHUNK-bit slice, carrying between chunks in one register. Operands are
//   captured on acceptance; {cout, s} == a + b + cin once out_valid is high.
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high
//     bus    : serial_chunk_adder_if.slave (in_valid/in_ready, a, b, cin,
//              s, cout, out_valid/out_ready)
//   Optional feature macro: SERIAL_ADDER_SUB_EN adds 'sub' on the bus; with
//   sub=1 the block returns a - b and cout=1 meaning "no borrow" (a >= b).
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | in_ready=1, waiting for operands
//   RUN    | adding one chunk per cycle, idx selects the chunk
//   DONE   | out_valid=1, s/cout held until out_ready
module serial_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   serial_chunk_adder_if.slave  bus
);

   localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_err
      $error("serial_chunk_adder: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;

   logic [WIDTH-1:0] b_load;
   logic             carry_load;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] sum_chunk;
   logic             c_chunk;
   logic             last_chunk;

   // Subtraction is a + ~b + 1, so it only changes what gets loaded.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = bus.sub ? ~bus.b : bus.b;
   assign carry_load = bus.sub ? 1'b1   : bus.cin;
`else
   assign b_load     = bus.b;
   assign carry_load = bus.cin;
`endif

   assign a_chunk    = a_q[int'(idx_q) * CHUNK +: CHUNK];
   assign b_chunk    = b_q[int'(idx_q) * CHUNK +: CHUNK];
   assign {c_chunk, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                               + {{CHUNK{1'b0}}, carry_q};
   assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      s_d     = s_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = b_load;
               carry_d = carry_load;
               idx_d   = '0;
               s_d     = '0;
               cout_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            s_d[int'(idx_q) * CHUNK +: CHUNK] = sum_chunk;
            carry_d = c_chunk;
            if (last_chunk) begin
               // idx parks at 0 so a single-chunk configuration never moves it.
               cout_d  = c_chunk;
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.s         = s_q;
   assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder
//   Scoreboard bench: accepted operands push the arithmetic result a+b+cin
//   (or a-b with borrow flag) into a queue; a monitor compares every cycle the
//   DUT shows out_valid and pops on handshake. A second instance with
//   CHUNK==WIDTH covers the single-cycle case.
module tb_serial_chunk_adder;

   localparam int W   = 16;
   localparam int C   = 4;
   localparam int NCH = W / C;

   logic clk = 1'b0;
   logic reset;

   serial_chunk_adder_if #(.WIDTH(W)) bus16 ();
   serial_chunk_adder_if #(.WIDTH(8))  bus8 ();

   serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16.slave)
   );

   serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   int           n_cmp    = 0;
   int           n_err    = 0;
   int           cyc      = 0;
   int           acc_cyc  = 0;
   int           rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high
   logic         prev_ov  = 1'b0;
   logic [W:0]   exp_q[$];

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sb);
      logic [W:0] r;
      if (sb) begin
         r[W-1:0] = a - b;
         r[W]     = (a >= b);
      end else begin
         r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end
      return r;
   endfunction

   // consumer side: out_ready updated after the edge, well before the sample point
   initial begin
      bus16.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       bus16.out_ready = ($urandom_range(0, 3) != 0);
            1:       bus16.out_ready = 1'b0;
            default: bus16.out_ready = 1'b1;
         endcase
      end
   end

   // monitor / scoreboard
   initial forever begin
      logic sb;
      @(negedge clk);
      if (reset) begin
         exp_q.delete();
         prev_ov = 1'b0;
      end else begin
`ifdef SERIAL_ADDER_SUB_EN
         sb = bus16.sub;
`else
         sb = 1'b0;
`endif
         if (bus16.in_valid && bus16.in_ready) begin
            exp_q.push_back(model(bus16.a, bus16.b, bus16.cin, sb));
            acc_cyc = cyc + 1;
         end
         if (bus16.out_valid) begin
            if (!prev_ov) chk("latency", 32'(cyc - acc_cyc), NCH);
            chk("in_ready_in_done", 32'(bus16.in_ready), 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'(exp_q.size()), 1);
            end else begin
               chk("sum", 32'(bus16.s), 32'(exp_q[0][W-1:0]));
               chk("cout", 32'(bus16.cout), 32'(exp_q[0][W]));
               if (bus16.out_ready) void'(exp_q.pop_front());
            end
         end
         prev_ov = bus16.out_valid;
      end
   end

   // call at posedge+1; returns at posedge+1 just after the accepting edge
   task automatic send16(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sb);
      bit acc = 1'b0;
      bus16.a   = a;
      bus16.b   = b;
      bus16.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
      bus16.sub = sb;
`endif
      bus16.in_valid = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         acc = bus16.in_ready;
         @(posedge clk);
         #1;
      end
      chk("accepted", 32'(acc), 1);
      bus16.in_valid = 1'b0;
      bus16.a   = W'($urandom);
      bus16.b   = W'($urandom);
      bus16.cin = 1'($urandom);
      if (sb) bus16.cin = 1'($urandom);
   endtask

   task automatic wait_result_check(input string name, input logic [W-1:0] s_exp,
                                    input logic cout_exp);
      repeat (NCH) @(posedge clk);
      #1;
      chk({name, "_valid"}, 32'(bus16.out_valid), 1);
      chk({name, "_s"},     32'(bus16.s), 32'(s_exp));
      chk({name, "_cout"},  32'(bus16.cout), 32'(cout_exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic [7:0]   a8, b8;
      logic         c8, rs;
      logic [8:0]   e8;

      reset          = 1'b1;
      bus16.in_valid = 1'b0;
      bus16.a        = '0;
      bus16.b        = '0;
      bus16.cin      = 1'b0;
      bus8.in_valid  = 1'b0;
      bus8.a         = '0;
      bus8.b         = '0;
      bus8.cin       = 1'b0;
      bus8.out_ready = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      bus16.sub      = 1'b0;
      bus8.sub       = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(bus16.in_ready), 1);
      chk("rst_out_valid", 32'(bus16.out_valid), 0);
      chk("rst_s",         32'(bus16.s), 0);
      chk("rst_cout",      32'(bus16.cout), 0);
      reset = 1'b0;

      rdy_mode = 2;
      @(posedge clk);
      #1;
      send16(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_result_check("dir_5555", 16'h5555, 1'b0);
      send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_result_check("dir_ripple", 16'h0000, 1'b1);

      // hold in DONE with out_ready low while new operands are offered
      rdy_mode = 1;
      @(posedge clk);
      #1;
      send16(16'hABCD, 16'h1111, 1'b1, 1'b0);
      repeat (NCH) @(posedge clk);
      #1;
      chk("hold_enter_valid", 32'(bus16.out_valid), 1);
      for (int i = 0; i < 3; i++) begin
         bus16.in_valid = 1'b1;
         bus16.a        = W'($urandom);
         bus16.b        = W'($urandom);
         @(posedge clk);
         #1;
         chk("hold_valid",    32'(bus16.out_valid), 1);
         chk("hold_in_ready", 32'(bus16.in_ready), 0);
         chk("hold_s",        32'(bus16.s), 32'h0000BCDF);
         chk("hold_cout",     32'(bus16.cout), 0);
      end
      bus16.in_valid = 1'b0;
      rdy_mode       = 2;
      @(posedge clk);
      #1;
      chk("release_in_ready",  32'(bus16.in_ready), 1);
      chk("release_out_valid", 32'(bus16.out_valid), 0);

      // asynchronous reset two cycles into RUN
      send16(16'h00FF, 16'h0F0F, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 32'(bus16.out_valid), 0);
      chk("arst_s",         32'(bus16.s), 0);
      chk("arst_cout",      32'(bus16.cout), 0);
      chk("arst_in_ready",  32'(bus16.in_ready), 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send16(16'h0001, 16'h0002, 1'b0, 1'b0);
      wait_result_check("after_rst", 16'h0003, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
      send16(16'd5, 16'd7, 1'b0, 1'b1);
      wait_result_check("sub_neg", 16'hFFFE, 1'b0);
      send16(16'd7, 16'd5, 1'b1, 1'b1);
      wait_result_check("sub_pos", 16'h0002, 1'b1);
`endif

      // randomized traffic with random back-pressure
      rdy_mode = 0;
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 8 == 0) ra = 16'hFFFF;
         if (i % 8 == 1) rb = 16'hFFFF;
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         send16(ra, rb, 1'($urandom), rs);
      end
      rdy_mode = 2;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 0);

      // single-chunk instance: result one cycle after acceptance
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            a8 = 8'h80;
            b8 = 8'h80;
            c8 = 1'b1;
         end else begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
         end
         e8 = {1'b0, a8} + {1'b0, b8} + {8'h00, c8};
         chk("w8_in_ready", 32'(bus8.in_ready), 1);
         bus8.a        = a8;
         bus8.b        = b8;
         bus8.cin      = c8;
         bus8.in_valid = 1'b1;
         @(posedge clk);
         #1;
         bus8.in_valid = 1'b0;
         chk("w8_run_not_valid", 32'(bus8.out_valid), 0);
         @(posedge clk);
         #1;
         chk("w8_valid", 32'(bus8.out_valid), 1);
         chk("w8_s",     32'(bus8.s), 32'(e8[7:0]));
         chk("w8_cout",  32'(bus8.cout), 32'(e8[8]));
         if (i == 0) chk("w8_dir_s", 32'(bus8.s), 32'h01);
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
